// File: rtl/cpu_sram_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_sram_arbiter
//
// Purpose:
//   Shares one synchronous single-port SRAM between the instruction-fetch
//   port and the load/store port. Data requests win by default. Each data win
//   taken while a fetch is waiting adds to a starvation counter. When the
//   counter reaches STARVE_LIMIT, the next grant goes to the fetch port.
//
// Handshake (both requester ports):
//   req is held high by the requester until addr_ok. addr_ok is the
//   combinational acceptance in the same cycle, and the SRAM access is issued
//   in that cycle. data_ok follows exactly one cycle later. The requester must
//   take it; responses cannot be stalled.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   inst_req/inst_addr         fetch request
//   inst_addr_ok               fetch accepted this cycle
//   inst_data_ok/inst_rdata    fetch response (one cycle after accept)
//   data_req/data_wr/data_wstrb/data_addr/data_wdata   load/store request
//   data_addr_ok               load/store accepted this cycle
//   data_data_ok/data_rdata    load/store response (stores respond too)
//   mem_en/mem_we/mem_addr/mem_wdata   SRAM command
//   mem_rdata                  SRAM read data, valid the cycle after mem_en
// ---------------------------------------------------------------------------
module cpu_sram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic       data_win;
    logic       inst_win;
    logic       starve_hit;
    logic       resp_vld;   // an access was issued last cycle
    logic       resp_src;   // 1 = that access belonged to the data port
    logic [3:0] starve_cnt;

    // Grant selection. Reset masks both grants, so no access is issued while
    // reset is high and no response follows.
    always_comb begin
        starve_hit = inst_req && (starve_cnt == LIMIT);
        data_win   = !reset && data_req && !starve_hit;
        inst_win   = !reset && inst_req && !data_win;
    end

    // SRAM command and accept strobes for the winning port.
    always_comb begin
        inst_addr_ok = inst_win;
        data_addr_ok = data_win;
        mem_en       = inst_win || data_win;
        mem_we       = 4'b0000;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        if (data_win) begin
            mem_we    = data_wr ? data_wstrb : 4'b0000;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else if (inst_win) begin
            mem_addr  = inst_addr;
        end
    end

    // Response tracking and starvation counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_vld   <= 1'b0;
            resp_src   <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            resp_vld <= inst_win || data_win;
            resp_src <= data_win;
            // The counter only measures data wins taken while a fetch is waiting.
            if (inst_win || !inst_req) begin
                starve_cnt <= 4'd0;
            end else if (data_win && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // Response routing. Reset also masks a response that is still in flight.
    always_comb begin
        inst_data_ok = !reset && resp_vld && !resp_src;
        data_data_ok = !reset && resp_vld && resp_src;
        inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
        data_rdata   = data_data_ok ? mem_rdata : 32'h0;
    end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu_sram_arbiter
//
// Testbench for cpu_sram_arbiter. A small SRAM model answers the DUT's
// memory port. Grant expectations are checked inline in each test task.
// Responses are checked by a scoreboard. It fills its queue when a grant is
// seen and drains it one cycle later.
// ---------------------------------------------------------------------------
module tb_cpu_sram_arbiter;
    localparam int unsigned STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {check_rdata, is_data_port, rdata}
    logic [33:0] exp_q[$];
    logic [31:0] sram [0:255];

    cpu_sram_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- SRAM model (read-first, byte writes) ----------------
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= sram[mem_addr[9:2]];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- scoreboard ----------------
    // Runs 2 time units after each falling edge. This is after the test tasks
    // have driven their inputs, so the grant outputs have settled.
    always begin
        logic [33:0] e;
        @(negedge clk);
        #2;
        if (reset === 1'b1) begin
            checks++;
            if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 ||
                inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
                errors++;
                $display("FAIL resp_in_reset got ok=%b%b rdata=%h/%h want 00 0/0",
                         inst_data_ok, data_data_ok, inst_rdata, data_rdata);
            end
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (e[32]) begin
                    if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || inst_rdata !== 32'h0 ||
                        (e[33] && data_rdata !== e[31:0])) begin
                        errors++;
                        $display("FAIL resp_data got ok=%b%b rdata=%h inst_rdata=%h want ok=01 rdata=%h",
                                 inst_data_ok, data_data_ok, data_rdata, inst_rdata, e[31:0]);
                    end
                end else begin
                    if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 ||
                        inst_rdata !== e[31:0] || data_rdata !== 32'h0) begin
                        errors++;
                        $display("FAIL resp_inst got ok=%b%b rdata=%h data_rdata=%h want ok=10 rdata=%h",
                                 inst_data_ok, data_data_ok, inst_rdata, data_rdata, e[31:0]);
                    end
                end
            end else begin
                checks++;
                if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 ||
                    inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL resp_spurious got ok=%b%b rdata=%h/%h want 00 0/0",
                             inst_data_ok, data_data_ok, inst_rdata, data_rdata);
                end
            end
            if (inst_addr_ok === 1'b1 && data_addr_ok === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL double_grant got inst_addr_ok=1 data_addr_ok=1 want at most one");
            end else if (data_addr_ok === 1'b1) begin
                exp_q.push_back({!data_wr, 1'b1, sram[data_addr[9:2]]});
            end else if (inst_addr_ok === 1'b1) begin
                exp_q.push_back({1'b1, 1'b0, sram[inst_addr[9:2]]});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic ireq, input logic [31:0] iaddr,
                         input logic dreq, input logic dwr, input logic [3:0] strb,
                         input logic [31:0] daddr, input logic [31:0] wdata);
        @(negedge clk);
        reset      = rst;
        inst_req   = ireq;
        inst_addr  = iaddr;
        data_req   = dreq;
        data_wr    = dwr;
        data_wstrb = strb;
        data_addr  = daddr;
        data_wdata = wdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h1c00_0000, 1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0);
            #1;
            checks++;
            if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0 || mem_en !== 1'b0 || mem_we !== 4'h0) begin
                errors++;
                $display("FAIL reset_hold got addr_ok=%b%b mem_en=%b mem_we=%h want 00 0 0",
                         inst_addr_ok, data_addr_ok, mem_en, mem_we);
            end
        end
        drive(1'b0, 1'b1, 32'h1c00_0000, 1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0);
        #1;
        checks++;
        if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0 || mem_addr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL reset_first_grant got addr_ok=%b%b mem_addr=%h want 01 00000100",
                     inst_addr_ok, data_addr_ok, mem_addr);
        end
        idle(2);
    endtask

    task automatic test_single_load();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hf, 32'h1000_0040, 32'hffff_ffff);
        #1;
        checks++;
        if (data_addr_ok !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'h0 || mem_addr !== 32'h1000_0040) begin
            errors++;
            $display("FAIL load_grant got addr_ok=%b en=%b we=%h addr=%h want 1 1 0 10000040",
                     data_addr_ok, mem_en, mem_we, mem_addr);
        end
        idle(1);
        #1;
        checks++;
        if (data_data_ok !== 1'b1 || data_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL load_resp got ok=%b rdata=%h want 1 deadbeef", data_data_ok, data_rdata);
        end
        idle(1);
    endtask

    task automatic test_store();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h0000_0080, 32'h1234_5678);
        #1;
        checks++;
        if (data_addr_ok !== 1'b1 || mem_we !== 4'b0011 || mem_wdata !== 32'h1234_5678 ||
            mem_addr !== 32'h0000_0080) begin
            errors++;
            $display("FAIL store_grant got ok=%b we=%b wdata=%h addr=%h want 1 0011 12345678 00000080",
                     data_addr_ok, mem_we, mem_wdata, mem_addr);
        end
        // Read the word back: the upper half is the preloaded word 32, the
        // lower half comes from the store.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_0080, 32'h0);
        #1;
        checks++;
        if (data_data_ok !== 1'b1) begin
            errors++;
            $display("FAIL store_resp got data_data_ok=%b want 1", data_data_ok);
        end
        idle(1);
        #1;
        checks++;
        if (data_rdata !== 32'hA5A5_5678) begin
            errors++;
            $display("FAIL store_readback got %h want a5a55678", data_rdata);
        end
        idle(1);
    endtask

    task automatic test_starvation();
        string pat = "DDDDIDDDDIDD";
        logic exp_d;
        for (int i = 0; i < pat.len(); i++) begin
            drive(1'b0, 1'b1, 32'h1c00_0000 + 32'(4*i), 1'b1, 1'b0, 4'h0, 32'h0000_0200 + 32'(4*i), 32'h0);
            #1;
            exp_d = (pat[i] == "D");
            checks++;
            if ({inst_addr_ok, data_addr_ok} !== {!exp_d, exp_d}) begin
                errors++;
                $display("FAIL starve_order[%0d] got addr_ok(i,d)=%b%b want %b%b",
                         i, inst_addr_ok, data_addr_ok, !exp_d, exp_d);
            end
        end
        idle(2);
    endtask

    // Dropping inst_req clears the counter, so the fetch waits a full STARVE_LIMIT again.
    task automatic test_starve_clear();
        string pat = "DDDDDDDI";
        logic exp_d;
        logic ireq;
        for (int i = 0; i < pat.len(); i++) begin
            ireq = (i != 2);
            drive(1'b0, ireq, 32'h1c00_0040, 1'b1, 1'b0, 4'h0, 32'h0000_0300, 32'h0);
            #1;
            exp_d = (pat[i] == "D");
            checks++;
            if ({inst_addr_ok, data_addr_ok} !== {!exp_d, exp_d}) begin
                errors++;
                $display("FAIL starve_clear[%0d] got addr_ok(i,d)=%b%b want %b%b",
                         i, inst_addr_ok, data_addr_ok, !exp_d, exp_d);
            end
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 32'h1c00_0000 + 32'(4*i), 1'b0, 1'b1, 4'hf, 32'h0000_0044, 32'hbad0_bad0);
            #1;
            checks++;
            if (inst_addr_ok !== 1'b1 || mem_addr !== 32'h1c00_0000 + 32'(4*i) ||
                mem_we !== 4'h0 || mem_wdata !== 32'h0) begin
                errors++;
                $display("FAIL b2b_fetch[%0d] got ok=%b addr=%h we=%h wdata=%h want 1 %h 0 0",
                         i, inst_addr_ok, mem_addr, mem_we, mem_wdata, 32'h1c00_0000 + 32'(4*i));
            end
        end
        idle(1);
        #1;
        checks++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== 32'hA5A5_0002) begin
            errors++;
            $display("FAIL b2b_last got ok=%b rdata=%h want 1 a5a50002", inst_data_ok, inst_rdata);
        end
        idle(1);
    endtask

    task automatic test_reset_mid();
        // Three data wins with a fetch waiting bring the counter to 3.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'h1c00_0000, 1'b1, 1'b0, 4'h0, 32'h0000_0400, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        checks++;
        if (data_data_ok !== 1'b0 || data_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_resp got ok=%b rdata=%h want 0 0", data_data_ok, data_rdata);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        checks++;
        if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after got ok=%b%b want 00", inst_data_ok, data_data_ok);
        end
        // A cleared counter means four data wins again before the fetch is granted.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 32'h1c00_0000, 1'b1, 1'b0, 4'h0, 32'h0000_0400, 32'h0);
            #1;
            checks++;
            if ({inst_addr_ok, data_addr_ok} !== ((i == 4) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL reset_mid_cnt[%0d] got addr_ok(i,d)=%b%b want %b",
                         i, inst_addr_ok, data_addr_ok, (i == 4) ? 2'b10 : 2'b01);
            end
        end
        idle(2);
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        for (int i = 0; i < 256; i++) sram[i] = 32'hA5A5_0000 | 32'(i);
        sram[16] = 32'hDEAD_BEEF;
        reset = 1'b1; inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;

        test_reset();
        test_single_load();
        test_store();
        test_starvation();
        test_starve_clear();
        test_back_to_back();
        test_reset_mid();
        idle(2);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending responses want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
